// File: rtl/uc_loader_pkg.sv
// uc_loader_pkg: shared types and constants for the uC serial register loader.
// Holds the loader state enum, sticky error codes and default header bytes.
package uc_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PAYLOAD,
      S_PARITY,
      S_COMMIT,
      S_PEND,
      S_DRAIN
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_HDR     = 3'd1;
   localparam logic [2:0] ERR_TRUNC   = 3'd2;
   localparam logic [2:0] ERR_PARITY  = 3'd3;
   localparam logic [2:0] ERR_OVERRUN = 3'd4;

   localparam logic [7:0] HDR_DYN_DEF  = 8'hD1;
   localparam logic [7:0] HDR_STAT_DEF = 8'h5A;

endpackage

// File: rtl/uc_sync_edge.sv
// uc_sync_edge: 2-flop synchroniser with registered rise/fall strobes.
// Ports: clk, rst_n (async low), d (async in), q (synced level), rise, fall.
module uc_sync_edge
   import uc_loader_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   // Strobes are registered so a pin edge shows up three clocks later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= RST_VAL;
         s2   <= RST_VAL;
         s3   <= RST_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= d;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
         fall <= ~s2 & s3;
      end
   end

   assign q = s2;

endmodule

// File: rtl/uc_reg_loader.sv
// uc_reg_loader: receives dynamic/static register images over a 3-wire uC link
// and commits them to held parallel words with one-cycle update strobes.
// Ports: CLK, RST_N, UC_CS_N/UC_SCLK/UC_MOSI (async serial), SR_BUSY, ERR_CLR,
// DYNREG, STATREG, UPD_DYN, UPD_STAT, BUSY, ERR_CODE.
// Option: define UC_REG_LOADER_PARITY_EN to expect a trailing even-parity bit.
module uc_reg_loader
   import uc_loader_pkg::*;
#(
   parameter int                    SIZESRDYN  = 16,
   parameter int                    SIZESRSTAT = 88,
   parameter logic [7:0]            HDR_DYN    = HDR_DYN_DEF,
   parameter logic [7:0]            HDR_STAT   = HDR_STAT_DEF,
   parameter logic [SIZESRDYN-1:0]  DYN_RST    = 16'h1234,
   parameter logic [SIZESRSTAT-1:0] STAT_RST   = 88'hABCDEF123456789ABCDEF1
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  UC_CS_N,
   input  logic                  UC_SCLK,
   input  logic                  UC_MOSI,
   input  logic                  SR_BUSY,
   input  logic                  ERR_CLR,
   output logic [SIZESRDYN-1:0]  DYNREG,
   output logic [SIZESRSTAT-1:0] STATREG,
   output logic                  UPD_DYN,
   output logic                  UPD_STAT,
   output logic                  BUSY,
   output logic [2:0]            ERR_CODE
);

   localparam int CW = $clog2(SIZESRSTAT + 1);

   state_t st;
   state_t nxt;

   logic                  sclk_lvl;
   logic                  bit_stb;
   logic                  sclk_fall;
   logic                  cs_lvl;
   logic                  cs_rise;
   logic                  frm_start;
   logic                  mosi_m;
   logic                  mosi;
   logic                  unused_ok;

   logic [CW-1:0]         cnt;
   logic [7:0]            hdr;
   logic [7:0]            hdr_nx;
   logic [SIZESRSTAT-1:0] stage;
   logic                  is_stat;
   logic                  hdr_last;
   logic                  pay_last;
   logic                  commit;
   logic                  err_set;
   logic [2:0]            err_val;
`ifdef UC_REG_LOADER_PARITY_EN
   logic                  par;
`endif

   uc_sync_edge #(.RST_VAL(1'b0)) u_sclk (
      .clk   (CLK),
      .rst_n (RST_N),
      .d     (UC_SCLK),
      .q     (sclk_lvl),
      .rise  (bit_stb),
      .fall  (sclk_fall)
   );

   uc_sync_edge #(.RST_VAL(1'b1)) u_cs (
      .clk   (CLK),
      .rst_n (RST_N),
      .d     (UC_CS_N),
      .q     (cs_lvl),
      .rise  (cs_rise),
      .fall  (frm_start)
   );

   assign unused_ok = sclk_lvl ^ sclk_fall;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mosi_m <= 1'b0;
         mosi   <= 1'b0;
      end else begin
         mosi_m <= UC_MOSI;
         mosi   <= mosi_m;
      end
   end

   assign hdr_nx   = {hdr[6:0], mosi};
   assign hdr_last = (cnt == CW'(7));
   assign pay_last = is_stat ? (cnt == CW'(SIZESRSTAT - 1))
                             : (cnt == CW'(SIZESRDYN - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st <= S_IDLE;
      end else begin
         st <= nxt;
      end
   end

   always_comb begin
      nxt     = st;
      commit  = 1'b0;
      err_set = 1'b0;
      err_val = ERR_NONE;
      unique case (st)
         S_IDLE: begin
            if (frm_start) nxt = S_HDR;
         end
         S_HDR: begin
            if (cs_rise) begin
               err_set = 1'b1;
               err_val = ERR_TRUNC;
               nxt     = S_IDLE;
            end else if (bit_stb && hdr_last) begin
               if (hdr_nx == HDR_DYN || hdr_nx == HDR_STAT) begin
                  nxt = S_PAYLOAD;
               end else begin
                  err_set = 1'b1;
                  err_val = ERR_HDR;
                  nxt     = S_DRAIN;
               end
            end
         end
         S_PAYLOAD: begin
            if (cs_rise) begin
               err_set = 1'b1;
               err_val = ERR_TRUNC;
               nxt     = S_IDLE;
            end else if (bit_stb && pay_last) begin
`ifdef UC_REG_LOADER_PARITY_EN
               nxt = S_PARITY;
`else
               nxt = S_COMMIT;
`endif
            end
         end
`ifdef UC_REG_LOADER_PARITY_EN
         S_PARITY: begin
            if (cs_rise) begin
               err_set = 1'b1;
               err_val = ERR_TRUNC;
               nxt     = S_IDLE;
            end else if (bit_stb) begin
               if (par ^ mosi) begin
                  err_set = 1'b1;
                  err_val = ERR_PARITY;
                  nxt     = S_DRAIN;
               end else begin
                  nxt = S_COMMIT;
               end
            end
         end
`endif
         S_COMMIT: begin
            if (!SR_BUSY) begin
               commit = 1'b1;
               nxt    = S_DRAIN;
            end else begin
               nxt = S_PEND;
            end
         end
         S_PEND: begin
            // A new frame here is dropped; the held image still commits.
            if (frm_start) begin
               err_set = 1'b1;
               err_val = ERR_OVERRUN;
            end
            if (!SR_BUSY) begin
               commit = 1'b1;
               nxt    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cs_lvl) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt     <= '0;
         hdr     <= '0;
         stage   <= '0;
         is_stat <= 1'b0;
`ifdef UC_REG_LOADER_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         if (st == S_IDLE) begin
            cnt <= '0;
`ifdef UC_REG_LOADER_PARITY_EN
            par <= 1'b0;
`endif
         end
         if (bit_stb && st == S_HDR) begin
            hdr <= hdr_nx;
            cnt <= hdr_last ? '0 : cnt + CW'(1);
            if (hdr_last) is_stat <= (hdr_nx == HDR_STAT);
`ifdef UC_REG_LOADER_PARITY_EN
            par <= par ^ mosi;
`endif
         end
         if (bit_stb && st == S_PAYLOAD) begin
            stage <= {stage[SIZESRSTAT-2:0], mosi};
            cnt   <= cnt + CW'(1);
`ifdef UC_REG_LOADER_PARITY_EN
            par   <= par ^ mosi;
`endif
         end
      end
   end

   // Dynamic frames use only the low bits of the shared staging register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DYNREG   <= DYN_RST;
         STATREG  <= STAT_RST;
         UPD_DYN  <= 1'b0;
         UPD_STAT <= 1'b0;
      end else begin
         UPD_DYN  <= 1'b0;
         UPD_STAT <= 1'b0;
         if (commit) begin
            if (is_stat) begin
               STATREG  <= stage;
               UPD_STAT <= 1'b1;
            end else begin
               DYNREG   <= stage[SIZESRDYN-1:0];
               UPD_DYN  <= 1'b1;
            end
         end
      end
   end

   // First error sticks; a clear coinciding with a new error keeps the new one.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ERR_CODE <= ERR_NONE;
      end else if (err_set && (ERR_CODE == ERR_NONE || ERR_CLR)) begin
         ERR_CODE <= err_val;
      end else if (ERR_CLR) begin
         ERR_CODE <= ERR_NONE;
      end
   end

   assign BUSY = !(st == S_IDLE || st == S_DRAIN);

endmodule

// File: tb/tb_uc_reg_loader.sv
// tb_uc_reg_loader: directed serial frames against a frame-level model
// of the loader's committed registers and sticky error code.
module tb_uc_reg_loader;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        UC_CS_N = 1'b1;
   logic        UC_SCLK = 1'b0;
   logic        UC_MOSI = 1'b0;
   logic        SR_BUSY = 1'b0;
   logic        ERR_CLR = 1'b0;
   logic [15:0] DYNREG;
   logic [87:0] STATREG;
   logic        UPD_DYN;
   logic        UPD_STAT;
   logic        BUSY;
   logic [2:0]  ERR_CODE;

   always #5 CLK = ~CLK;

   uc_reg_loader dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .UC_CS_N  (UC_CS_N),
      .UC_SCLK  (UC_SCLK),
      .UC_MOSI  (UC_MOSI),
      .SR_BUSY  (SR_BUSY),
      .ERR_CLR  (ERR_CLR),
      .DYNREG   (DYNREG),
      .STATREG  (STATREG),
      .UPD_DYN  (UPD_DYN),
      .UPD_STAT (UPD_STAT),
      .BUSY     (BUSY),
      .ERR_CODE (ERR_CODE)
   );

   localparam logic [15:0] DRST = 16'h1234;
   localparam logic [87:0] SRST = 88'hABCDEF123456789ABCDEF1;
   localparam logic [87:0] SVAL = 88'h0123456789ABCDEF012345;

   typedef struct packed {
      logic        is_stat;
      logic [87:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          exp_upd_cyc = 0;
   int          last_rise = 0;
   bit          quiet = 1'b0;
   bit          started = 1'b0;
   bit          prev_dyn = 1'b0;
   bit          prev_stat = 1'b0;
   logic [15:0] m_dyn = DRST;
   logic [87:0] m_stat = SRST;
   logic [2:0]  m_err = 3'd0;

   task automatic chk(input string name, input logic [87:0] act,
                      input logic [87:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (started && RST_N) begin
         if (UPD_DYN) begin
            if (exp_q.size() != 0 && !exp_q[0].is_stat) begin
               m_dyn = exp_q[0].val[15:0];
               void'(exp_q.pop_front());
               chk("upd_dyn_cyc", 88'(cyc), 88'(exp_upd_cyc));
            end else begin
               chk("upd_dyn_unexpected", 88'(UPD_DYN), 88'(0));
            end
            chk("upd_dyn_single", 88'(prev_dyn), 88'(0));
         end
         if (UPD_STAT) begin
            if (exp_q.size() != 0 && exp_q[0].is_stat) begin
               m_stat = exp_q[0].val;
               void'(exp_q.pop_front());
               chk("upd_stat_cyc", 88'(cyc), 88'(exp_upd_cyc));
            end else begin
               chk("upd_stat_unexpected", 88'(UPD_STAT), 88'(0));
            end
            chk("upd_stat_single", 88'(prev_stat), 88'(0));
         end
         chk("dynreg", 88'(DYNREG), 88'(m_dyn));
         chk("statreg", STATREG, m_stat);
         if (quiet) begin
            chk("err_code", 88'(ERR_CODE), 88'(m_err));
            chk("busy_idle", 88'(BUSY), 88'(0));
         end
      end
      prev_dyn  = UPD_DYN;
      prev_stat = UPD_STAT;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic set_err(input logic [2:0] code);
      if (m_err == 3'd0) m_err = code;
   endtask

   task automatic clr_err();
      quiet   = 1'b0;
      ERR_CLR = 1'b1;
      tick(1);
      ERR_CLR = 1'b0;
      m_err   = 3'd0;
      tick(1);
      quiet   = 1'b1;
      chk("err_cleared", 88'(ERR_CODE), 88'(0));
   endtask

   task automatic settle();
      tick(2);
      quiet = 1'b1;
      tick(4);
   endtask

   task automatic send_bit(input logic b);
      UC_MOSI = b;
      tick(4);
      UC_SCLK   = 1'b1;
      last_rise = cyc;
      tick(4);
      UC_SCLK = 1'b0;
   endtask

   // cut >= 0 raises chip-select after that many payload bits.
   task automatic send_frame(input logic [7:0] h, input int n,
                             input logic [87:0] d, input int cut,
                             input bit par_bad, input bit commits);
      logic p;
      logic b;
      p       = 1'b0;
      quiet   = 1'b0;
      UC_CS_N = 1'b0;
      tick(6);
      for (int i = 7; i >= 0; i--) begin
         send_bit(h[i]);
         p = p ^ h[i];
         if (i == 7) chk("busy_mid", 88'(BUSY), 88'(1));
      end
      for (int j = 0; j < n; j++) begin
         if (j == cut) break;
         b = d[n-1-j];
         send_bit(b);
         p = p ^ b;
      end
`ifdef UC_REG_LOADER_PARITY_EN
      if (cut < 0) send_bit(p ^ par_bad);
`endif
      if (commits && !SR_BUSY) exp_upd_cyc = last_rise + 5;
      tick(6);
      UC_CS_N = 1'b1;
      tick(8);
   endtask

   initial begin
      tick(3);
      RST_N = 1'b1;
      tick(2);
      started = 1'b1;
      quiet   = 1'b1;
      tick(20);
      chk("rst_dyn", 88'(DYNREG), 88'(16'h1234));
      chk("rst_stat", STATREG, 88'hABCDEF123456789ABCDEF1);
      chk("rst_upd_dyn", 88'(UPD_DYN), 88'(0));
      chk("rst_upd_stat", 88'(UPD_STAT), 88'(0));
      chk("rst_err", 88'(ERR_CODE), 88'(0));
      chk("rst_busy", 88'(BUSY), 88'(0));

      exp_q.push_back({1'b0, 88'hBEEF});
      send_frame(8'hD1, 16, 88'hBEEF, -1, 1'b0, 1'b1);
      settle();
      chk("dyn_beef", 88'(DYNREG), 88'(16'hBEEF));
      chk("stat_kept", STATREG, 88'hABCDEF123456789ABCDEF1);

      SR_BUSY = 1'b1;
      exp_q.push_back({1'b1, SVAL});
      send_frame(8'h5A, 88, SVAL, -1, 1'b0, 1'b1);
      tick(50);
      chk("pend_stat_held", STATREG, 88'hABCDEF123456789ABCDEF1);
      chk("pend_busy", 88'(BUSY), 88'(1));
      SR_BUSY     = 1'b0;
      exp_upd_cyc = cyc + 1;
      settle();
      chk("stat_new", STATREG, 88'h0123456789ABCDEF012345);

      send_frame(8'h00, 16, 88'h1111, -1, 1'b0, 1'b0);
      set_err(3'd1);
      settle();
      chk("err_bad_hdr", 88'(ERR_CODE), 88'(1));
      chk("dyn_after_bad", 88'(DYNREG), 88'(16'hBEEF));
      clr_err();

      send_frame(8'hD1, 16, 88'h7777, 7, 1'b0, 1'b0);
      set_err(3'd2);
      settle();
      chk("err_trunc", 88'(ERR_CODE), 88'(2));
      chk("dyn_after_trunc", 88'(DYNREG), 88'(16'hBEEF));
      clr_err();

      SR_BUSY = 1'b1;
      exp_q.push_back({1'b0, 88'hCAFE});
      send_frame(8'hD1, 16, 88'hCAFE, -1, 1'b0, 1'b1);
      send_frame(8'hD1, 16, 88'h5555, -1, 1'b0, 1'b0);
      set_err(3'd4);
      tick(10);
      chk("overrun_held", 88'(DYNREG), 88'(16'hBEEF));
      chk("err_overrun", 88'(ERR_CODE), 88'(4));
      SR_BUSY     = 1'b0;
      exp_upd_cyc = cyc + 1;
      settle();
      chk("dyn_cafe", 88'(DYNREG), 88'(16'hCAFE));
      clr_err();

`ifdef UC_REG_LOADER_PARITY_EN
      send_frame(8'hD1, 16, 88'h0001, -1, 1'b1, 1'b0);
      set_err(3'd3);
      settle();
      chk("err_parity", 88'(ERR_CODE), 88'(3));
      chk("dyn_after_par", 88'(DYNREG), 88'(16'hCAFE));
      clr_err();
      exp_q.push_back({1'b0, 88'h0001});
      send_frame(8'hD1, 16, 88'h0001, -1, 1'b0, 1'b1);
      settle();
      chk("dyn_par_ok", 88'(DYNREG), 88'(16'h0001));
`endif

      quiet   = 1'b0;
      UC_CS_N = 1'b0;
      tick(6);
      for (int k = 0; k < 20; k++) begin
         send_bit(k < 8 ? ((8'h5A >> (7 - k)) & 8'h01) != 0 : 1'b1);
      end
      RST_N  = 1'b0;
      m_dyn  = DRST;
      m_stat = SRST;
      m_err  = 3'd0;
      #1;
      chk("midrst_dyn", 88'(DYNREG), 88'(16'h1234));
      chk("midrst_stat", STATREG, 88'hABCDEF123456789ABCDEF1);
      chk("midrst_busy", 88'(BUSY), 88'(0));
      chk("midrst_err", 88'(ERR_CODE), 88'(0));
      UC_CS_N = 1'b1;
      UC_SCLK = 1'b0;
      tick(3);
      RST_N = 1'b1;
      settle();

      exp_q.push_back({1'b0, 88'hA5C3});
      send_frame(8'hD1, 16, 88'hA5C3, -1, 1'b0, 1'b1);
      settle();
      chk("dyn_a5c3", 88'(DYNREG), 88'(16'hA5C3));
      chk("queue_empty", 88'(exp_q.size()), 88'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
